serial_addsub_ctrl: RTL and testbench



---
 rtl/serial_addsub_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_ctrl
// Purpose  : Bit-serial sequencer around one external 1-bit full
//            adder/subtractor cell. It latches two N-bit operands and an
//            add/subtract command, then feeds the cell one bit per clock,
//            LSB first, holding the ripple carry/borrow in a register. When
//            the MSB has been processed it loads the result and the status
//            flags and pulses done for one cycle.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            start, add_ns         command request, 1 = add / 0 = subtract
//            op_a, op_b            N-bit operands, latched with start
//            abort                 cancel, honoured only while running
//            fa_a/fa_b/fa_cin/     drive the bit cell's a, b, cin, a_ns
//            fa_a_ns
//            fa_s, fa_cout         bit cell's sum and carry/borrow
//            busy, done            running flag, one-cycle completion pulse
//            result, carry, ovf,   final N-bit value, carry/borrow,
//            zero                  two's-complement overflow, result == 0
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         add_ns,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic         abort,
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_cin,
    output logic         fa_a_ns,
    input  logic         fa_s,
    input  logic         fa_cout,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         ovf,
    output logic         zero
);

    localparam int         CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_a_sh;
    logic [N-1:0]  r_b_sh;
    logic          r_op_q;
    logic          r_carry_q;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_result;
    logic          r_carry;
    logic          r_ovf;
    logic          r_zero;

    logic          w_run;
    logic          w_load;
    logic          w_shift;
    logic [N-1:0]  w_a_next;
    logic [N-1:0]  w_b_next;
    logic [N-1:0]  w_res_full;
    logic          w_ovf;

    assign w_run   = (r_state == S_RUN);
    assign w_load  = (r_state == S_IDLE) && start;
    assign w_shift = w_run && !abort;

    // Cell drive: the current bit sits at position 0 of each shift register.
    // Outside RUN the cell sees a quiet add of zeros.
    assign fa_a    = w_run & r_a_sh[0];
    assign fa_b    = w_run & r_b_sh[0];
    assign fa_cin  = w_run & r_carry_q;
    assign fa_a_ns = w_run ? r_op_q : 1'b1;

    // The partial result holds only the N-1 bits captured so far; the bit
    // coming out of the cell this cycle completes the word.
    generate
        if (N > 1) begin : g_wide
            logic [N-2:0] r_part;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_part <= '0;
                end else if (w_load) begin
                    r_part <= '0;
                end else if (w_shift) begin
                    r_part <= w_res_full[N-1:1];
                end
            end

            assign w_res_full = {fa_s, r_part};
            assign w_a_next   = {1'b0, r_a_sh[N-1:1]};
            assign w_b_next   = {1'b0, r_b_sh[N-1:1]};
        end else begin : g_narrow
            assign w_res_full = fa_s;
            assign w_a_next   = 1'b0;
            assign w_b_next   = 1'b0;
        end
    endgenerate

    // On the final bit the shift registers' bit 0 still holds the operand
    // MSBs, so overflow is judged from the live cell inputs and output.
    assign w_ovf = r_op_q ? ((r_a_sh[0] == r_b_sh[0]) && (fa_s != r_a_sh[0]))
                          : ((r_a_sh[0] != r_b_sh[0]) && (fa_s != r_a_sh[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_op_q    <= 1'b0;
            r_carry_q <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh    <= op_a;
                        r_b_sh    <= op_b;
                        r_op_q    <= add_ns;
                        r_carry_q <= 1'b0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Cancel wins over the final-bit capture; status
                        // outputs keep the previous completion's values.
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_carry_q <= fa_cout;
                        r_a_sh    <= w_a_next;
                        r_b_sh    <= w_b_next;
                        r_cnt     <= r_cnt + CW'(1);
                        if (r_cnt == C_LAST) begin
                            r_result <= w_res_full;
                            r_carry  <= fa_cout;
                            r_zero   <= (w_res_full == '0);
                            r_ovf    <= w_ovf;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign carry  = r_carry;
    assign ovf    = r_ovf;
    assign zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub_ctrl
// Purpose  : Self-checking bench for serial_addsub_ctrl. Models the external
//            bit cell, predicts each operation with a word-level reference
//            model and queues the expectation; completions pop and compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         add_ns;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         abort;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_a_ns;
    logic         fa_s;
    logic         fa_cout;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         carry;
    logic         ovf;
    logic         zero;

    int n_chk  = 0;
    int n_pass = 0;

    // {result, carry, ovf, zero}
    logic [N+2:0] sb_q[$];

    serial_addsub_ctrl #(.N(N)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .add_ns  (add_ns),
        .op_a    (op_a),
        .op_b    (op_b),
        .abort   (abort),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_a_ns (fa_a_ns),
        .fa_s    (fa_s),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry),
        .ovf     (ovf),
        .zero    (zero)
    );

    // External bit cell
    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = fa_a_ns ? ((fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin))
                             : ((~fa_a & fa_b) | (~(fa_a ^ fa_b) & fa_cin));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [N+2:0] ref_model(input logic add, input logic [N-1:0] a,
                                               input logic [N-1:0] b);
        logic [N:0]   w;
        logic [N-1:0] r;
        logic         c, v;
        if (add) begin
            w = {1'b0, a} + {1'b0, b};
            c = w[N];
        end else begin
            w = {1'b0, a} - {1'b0, b};
            c = (a < b);
        end
        r = w[N-1:0];
        if (add) v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
        else     v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
        return {r, c, v, (r == '0)};
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_fa"}, 32'({fa_a, fa_b, fa_cin, fa_a_ns}), 32'b0001);
    endtask

    // Called #1 after a rising edge with the DUT idle. Optionally pulses a
    // bogus start mid-run, which must have no effect.
    task automatic do_op(input logic add, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit inject_start);
        logic [N+2:0] e;
        int lat, busy_n;
        bit got;
        start = 1'b1; add_ns = add; op_a = a; op_b = b;
        sb_q.push_back(ref_model(add, a, b));
        @(posedge clk); #1;
        start = 1'b0; op_a = ~a; op_b = ~b; add_ns = ~add;
        lat = 0; busy_n = 0; got = 0;
        while (!got && lat < N + 4) begin
            if (busy) busy_n++;
            if (inject_start && lat == 2) start = 1'b1;
            if (inject_start && lat == 3) start = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (done) got = 1;
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("latency", 32'(lat), 32'(N));
        chk("busy_cycles", 32'(busy_n), 32'(N));
        if (got) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("result", 32'(result), 32'(e[N+2:3]));
                chk("carry",  32'(carry),  32'(e[2]));
                chk("ovf",    32'(ovf),    32'(e[1]));
                chk("zero",   32'(zero),   32'(e[0]));
            end
        end else begin
            void'(sb_q.pop_front());
        end
        @(posedge clk); #1;
        chk("done_width", 32'(done), 32'd0);
        check_idle("post");
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic         rop;
        rst_n = 1'b0; start = 1'b0; add_ns = 1'b0; op_a = '0; op_b = '0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({busy, done, carry, ovf, zero}), 32'd0);
        check_idle("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(1'b1, 8'h35, 8'h4A, 1'b0);
        do_op(1'b1, 8'hFF, 8'h01, 1'b0);
        do_op(1'b1, 8'h7F, 8'h01, 1'b0);
        do_op(1'b0, 8'h50, 8'h30, 1'b0);
        do_op(1'b0, 8'h30, 8'h50, 1'b0);
        do_op(1'b0, 8'h80, 8'h01, 1'b0);
        do_op(1'b1, 8'h35, 8'h4A, 1'b1);

        // Abort in the 4th RUN cycle
        start = 1'b1; add_ns = 1'b1; op_a = 8'h11; op_b = 8'h22;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_done", 32'(done), 32'd0);
        check_idle("abort");
        chk("abort_result", 32'(result), 32'h7F);
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk); #1;
            chk("abort_nodone", 32'(done), 32'd0);
        end

        // Asynchronous reset after 3 bits
        start = 1'b1; add_ns = 1'b1; op_a = 8'hC3; op_b = 8'h5A;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_flags", 32'({busy, done, carry, ovf, zero}), 32'd0);
        check_idle("arst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(1'b1, 8'h01, 8'h01, 1'b0);

        // Random back-to-back traffic
        for (int i = 0; i < 20; i++) begin
            ra  = N'($urandom);
            rb  = N'($urandom);
            rop = 1'($urandom);
            do_op(rop, ra, rb, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
